// File: rtl/note_lane_renderer_if.sv
// Control/pixel bundle between the game-control FSM, the note-lane renderer
// and the VGA adapter.
interface note_lane_renderer_if #(
  parameter int LANES = 3
);
  logic             start;
  logic             shift;
  logic             loopMode;
  logic [LANES-1:0] noteIn;
  logic [7:0]       vgaOutX;
  logic [6:0]       vgaOutY;
  logic [2:0]       vgaOutColour;
  logic             vgaPlot;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [LANES-1:0] hitNotes;

  modport master (
    output start, shift, loopMode, noteIn,
    input  vgaOutX, vgaOutY, vgaOutColour, vgaPlot, busy, done, overrun, hitNotes
  );

  modport slave (
    input  start, shift, loopMode, noteIn,
    output vgaOutX, vgaOutY, vgaOutColour, vgaPlot, busy, done, overrun, hitNotes
  );
endinterface

// File: rtl/note_lane_renderer.sv
// Note-highway renderer: LANES x DEPTH scrolling note pattern, painted box by
// box to the VGA adapter at one pixel per cycle on each start request.
module note_lane_renderer #(
  parameter int                     LANES        = 3,
  parameter int                     DEPTH        = 4,
  parameter int                     BOX_W        = 4,
  parameter int                     BOX_H        = 4,
  parameter int                     LANE_PITCH_X = 8,
  parameter int                     SLOT_PITCH_Y = 8,
  parameter int                     ORIGIN_X     = 0,
  parameter int                     ORIGIN_Y     = 80,
  parameter logic [LANES*DEPTH-1:0] INIT         = 12'h842,
  parameter logic [2:0]             COLOUR_ON    = 3'b000,
  parameter logic [2:0]             COLOUR_OFF   = 3'b111
) (
  input logic                 clock,
  input logic                 resetn,
  note_lane_renderer_if.slave bus
);

  localparam int NB = LANES * DEPTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t           state_q,      state_d;
  logic [NB-1:0]    pattern_q,    pattern_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_loop_q,  pend_loop_d;
  logic [LANES-1:0] pend_note_q,  pend_note_d;
  logic [LW-1:0]    lane_q,       lane_d;
  logic [SW-1:0]    slot_q,       slot_d;
  logic [RW-1:0]    row_q,        row_d;
  logic [CW-1:0]    col_q,        col_d;
  logic             last_q,       last_d;
  logic [7:0]       x_q,          x_d;
  logic [6:0]       y_q,          y_d;
  logic [2:0]       colour_q,     colour_d;
  logic             plot_q,       plot_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             overrun_q,    overrun_d;

  logic             emit_s;
  logic             at_last_s;
  logic [31:0]      pix_idx_s;
  logic [NB-1:0]    pat_sel_s;

  // One-slot scroll of every lane; the top slot takes the old hit slot or a new note.
  function automatic logic [NB-1:0] scroll(input logic [NB-1:0]    pat,
                                           input logic             loop_mode,
                                           input logic [LANES-1:0] notes);
    logic [NB-1:0] nxt;
    nxt = pat;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        nxt[l*DEPTH + k] = pat[l*DEPTH + k + 1];
      end
      nxt[l*DEPTH + DEPTH - 1] = loop_mode ? pat[l*DEPTH] : notes[l];
    end
    return nxt;
  endfunction

  assign at_last_s = (lane_q == LW'(LANES - 1)) && (slot_q == SW'(DEPTH - 1)) &&
                     (row_q  == RW'(BOX_H - 1)) && (col_q  == CW'(BOX_W - 1));

  // Next-state logic: scrolling, pending-shift bookkeeping, scan counters and pixel outputs.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    pend_valid_d = pend_valid_q;
    pend_loop_d  = pend_loop_q;
    pend_note_d  = pend_note_q;
    lane_d       = lane_q;
    slot_d       = slot_q;
    row_d        = row_q;
    col_d        = col_q;
    last_d       = last_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    emit_s       = 1'b0;
    pix_idx_s    = 32'd0;
    pat_sel_s    = '0;

    case (state_q)
      IDLE: begin
        // A shift in the same cycle as start lands first so the frame shows it.
        if (bus.shift) begin
          pattern_d = scroll(pattern_q, bus.loopMode, bus.noteIn);
        end else begin
          pattern_d = pattern_q;
        end
        if (bus.start) begin
          state_d = DRAW;
          busy_d  = 1'b1;
          emit_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = 1'b0;
          if (pend_valid_q) begin
            pattern_d    = scroll(pattern_q, pend_loop_q, pend_note_q);
            pend_valid_d = 1'b0;
            overrun_d    = bus.shift;
          end else if (bus.shift) begin
            pattern_d = scroll(pattern_q, bus.loopMode, bus.noteIn);
          end else begin
            pattern_d = pattern_q;
          end
        end else begin
          emit_s = 1'b1;
          if (bus.shift && pend_valid_q) begin
            overrun_d = 1'b1;
          end else if (bus.shift) begin
            pend_valid_d = 1'b1;
            pend_loop_d  = bus.loopMode;
            pend_note_d  = bus.noteIn;
          end else begin
            pend_valid_d = pend_valid_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Counters always sit on the next pixel to paint; they wrap to zero after the last one.
    if (emit_s) begin
      plot_d    = 1'b1;
      last_d    = at_last_s;
      pix_idx_s = 32'(lane_q) * 32'(DEPTH) + 32'(slot_q);
      pat_sel_s = pattern_d >> pix_idx_s;
      colour_d  = pat_sel_s[0] ? COLOUR_ON : COLOUR_OFF;
      x_d = 8'(32'(ORIGIN_X) + 32'(lane_q) * 32'(LANE_PITCH_X) + 32'(col_q));
      y_d = 7'(32'(ORIGIN_Y) + (32'(DEPTH - 1) - 32'(slot_q)) * 32'(SLOT_PITCH_Y) + 32'(row_q));
      if (col_q != CW'(BOX_W - 1)) begin
        col_d = col_q + CW'(1);
      end else if (row_q != RW'(BOX_H - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else if (slot_q != SW'(DEPTH - 1)) begin
        col_d  = '0;
        row_d  = '0;
        slot_d = slot_q + SW'(1);
      end else if (lane_q != LW'(LANES - 1)) begin
        col_d  = '0;
        row_d  = '0;
        slot_d = '0;
        lane_d = lane_q + LW'(1);
      end else begin
        col_d  = '0;
        row_d  = '0;
        slot_d = '0;
        lane_d = '0;
      end
    end else begin
      plot_d = 1'b0;
    end
  end

  // State and output registers; resetn low at an edge also aborts a draw in progress.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pattern_q    <= INIT;
      pend_valid_q <= 1'b0;
      pend_loop_q  <= 1'b0;
      pend_note_q  <= '0;
      lane_q       <= '0;
      slot_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      last_q       <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      pend_valid_q <= pend_valid_d;
      pend_loop_q  <= pend_loop_d;
      pend_note_q  <= pend_note_d;
      lane_q       <= lane_d;
      slot_q       <= slot_d;
      row_q        <= row_d;
      col_q        <= col_d;
      last_q       <= last_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.vgaOutX      = x_q;
  assign bus.vgaOutY      = y_q;
  assign bus.vgaOutColour = colour_q;
  assign bus.vgaPlot      = plot_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overrun      = overrun_q;

  for (genvar l = 0; l < LANES; l++) begin : g_hit
    assign bus.hitNotes[l] = pattern_q[l*DEPTH];
  end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench for note_lane_renderer with default parameters: expected
// pixels are queued when a draw is requested and popped as the DUT plots.
module tb_note_lane_renderer;

  localparam logic [11:0] INIT_PAT = 12'h842;

  logic clk;
  logic resetn;
  int   checks_cnt;
  int   errors_cnt;
  int   plot_cnt;
  logic [11:0] m_pat;
  logic [17:0] exp_q[$];

  note_lane_renderer_if #(.LANES(3)) bus ();

  note_lane_renderer dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference scroll: each lane nibble moves down one slot, new top bit on the left.
  function automatic logic [11:0] model_scroll(input logic [11:0] p, input logic lp,
                                               input logic [2:0] notes);
    logic [11:0] r;
    logic [3:0]  nib;
    for (int l = 0; l < 3; l++) begin
      nib = p[l*4 +: 4];
      r[l*4 +: 4] = {(lp ? nib[0] : notes[l]), nib[3:1]};
    end
    return r;
  endfunction

  function automatic logic [2:0] model_hit(input logic [11:0] p);
    return {p[8], p[4], p[0]};
  endfunction

  task automatic push_frame();
    int x;
    int y;
    logic [2:0] c;
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 4; s++)
        for (int r = 0; r < 4; r++)
          for (int cc = 0; cc < 4; cc++) begin
            x = l * 8 + cc;
            y = 80 + (3 - s) * 8 + r;
            c = m_pat[l*4 + s] ? 3'b000 : 3'b111;
            exp_q.push_back({8'(x), 7'(y), c});
          end
  endtask

  // Pixel monitor: every plotted pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [17:0] e;
    if (bus.vgaPlot === 1'b1) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        check("pix_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pix", {14'd0, bus.vgaOutX, bus.vgaOutY, bus.vgaOutColour}, {14'd0, e});
      end
    end
  end

  task automatic shift_idle(input logic lp, input logic [2:0] notes);
    @(negedge clk);
    bus.shift = 1'b1; bus.loopMode = lp; bus.noteIn = notes;
    m_pat = model_scroll(m_pat, lp, notes);
    @(negedge clk);
    bus.shift = 1'b0;
    check("hit_idle", {29'd0, bus.hitNotes}, {29'd0, model_hit(m_pat)});
  endtask

  // One frame; sh1/sh2/restart_at/abort_at are cycle numbers after start (0 = unused).
  task automatic run_frame(input bit sws, input logic [2:0] sws_notes, input int sh1,
                           input int sh2, input int restart_at, input int abort_at);
    int done_at;
    int ovr_at;
    int ovr_cnt;
    bit pend;
    bit aborted;
    logic [11:0] pend_pat;
    logic [2:0]  hit_before;
    done_at = 0; ovr_at = 0; ovr_cnt = 0; pend = 1'b0; aborted = 1'b0; pend_pat = m_pat;
    @(negedge clk);
    plot_cnt = 0;
    bus.start = 1'b1;
    if (sws) begin
      bus.shift = 1'b1; bus.loopMode = 1'b1; bus.noteIn = sws_notes;
      m_pat = model_scroll(m_pat, 1'b1, sws_notes);
    end
    push_frame();
    hit_before = model_hit(m_pat);
    for (int c = 1; c <= 400 && done_at == 0 && !aborted; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      bus.shift = 1'b0;
      if (bus.overrun === 1'b1) begin ovr_cnt++; ovr_at = c; end
      if (c == sh1) begin
        bus.shift = 1'b1; bus.loopMode = 1'b0; bus.noteIn = 3'b011;
        pend = 1'b1; pend_pat = model_scroll(m_pat, 1'b0, 3'b011);
      end
      if (c == sh2) begin
        bus.shift = 1'b1; bus.loopMode = 1'b0; bus.noteIn = 3'b110;
      end
      if (abort_at != 0 && c == abort_at) resetn = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        check("abort_plot", {31'd0, bus.vgaPlot}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        resetn = 1'b1;
        m_pat = INIT_PAT;
        exp_q.delete();
        check("abort_hit", {29'd0, bus.hitNotes}, {29'd0, model_hit(m_pat)});
        aborted = 1'b1;
      end else if (bus.done === 1'b1) begin
        done_at = c;
        check("done_busy", {31'd0, bus.busy}, 32'd0);
        if (pend) m_pat = pend_pat;
        check("hit_done", {29'd0, bus.hitNotes}, {29'd0, model_hit(m_pat)});
      end else if (sh1 != 0) begin
        check("hit_frozen", {29'd0, bus.hitNotes}, {29'd0, hit_before});
      end
    end
    bus.start = 1'b0;
    bus.shift = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
      end
    end else begin
      check("done_cycle", done_at, 32'd193);
      check("plot_count", plot_cnt, 32'd192);
      check("queue_empty", exp_q.size(), 32'd0);
      if (sh2 != 0) begin
        check("overrun_cnt", ovr_cnt, 32'd1);
        check("overrun_at", ovr_at, sh2 + 1);
      end else begin
        check("overrun_none", ovr_cnt, 32'd0);
      end
      @(negedge clk);
      check("done_pulse", {31'd0, bus.done}, 32'd0);
      check("idle_plot", {31'd0, bus.vgaPlot}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks_cnt = 0; errors_cnt = 0; plot_cnt = 0;
    m_pat = INIT_PAT;
    resetn = 1'b0;
    bus.start = 1'b0; bus.shift = 1'b0; bus.loopMode = 1'b0; bus.noteIn = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_plot",    {31'd0, bus.vgaPlot}, 32'd0);
    check("rst_busy",    {31'd0, bus.busy}, 32'd0);
    check("rst_done",    {31'd0, bus.done}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_xyc",     {14'd0, bus.vgaOutX, bus.vgaOutY, bus.vgaOutColour}, 32'd0);
    check("rst_hit",     {29'd0, bus.hitNotes}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) shift_idle(1'b1, 3'b000);
    run_frame(1'b0, 3'b000, 0, 0, 30, 0);

    shift_idle(1'b0, 3'b101);
    run_frame(1'b0, 3'b000, 0, 0, 0, 0);

    run_frame(1'b1, 3'b000, 0, 0, 0, 0);
    run_frame(1'b0, 3'b000, 10, 20, 0, 0);
    run_frame(1'b0, 3'b000, 0, 0, 0, 50);
    run_frame(1'b0, 3'b000, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
